// File: rtl/sparc_ctrl_pipe.sv
// Pipelined SPARC control unit: decodes the ID instruction and carries the
// control bundle through EX/MEM/WB registers with load-use bubble insertion.
module sparc_ctrl_pipe #(
   parameter logic EN_LOGIC      = 1'b1,
   parameter logic EN_SHIFT      = 1'b1,
   parameter logic HAZARD_DETECT = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr,
   input  logic        id_valid,
   input  logic        stall,
   input  logic        flush,
   output logic        id_hold,
   output logic        ex_valid,
   output logic [3:0]  ex_soh_op,
   output logic [3:0]  ex_alu_op,
   output logic        ex_cc_we,
   output logic        ex_use_cc,
   output logic        ex_b,
   output logic [3:0]  ex_cond,
   output logic        ex_j_l,
   output logic        ex_call,
   output logic        ex_illegal,
   output logic        mem_valid,
   output logic        mem_rw,
   output logic        mem_e,
   output logic [1:0]  mem_size,
   output logic        mem_se,
   output logic        mem_l,
   output logic        wb_valid,
   output logic        wb_rf_le,
   output logic [4:0]  wb_rd
);

   typedef struct packed {
      logic       valid;
      logic [3:0] soh_op;
      logic [3:0] alu_op;
      logic       cc_we;
      logic       use_cc;
      logic       b;
      logic [3:0] cond;
      logic       j_l;
      logic       call;
      logic       illegal;
      logic       rw;
      logic       e;
      logic [1:0] size;
      logic       se;
      logic       l;
      logic       rf_le;
      logic [4:0] rd;
   } ex_t;

   typedef struct packed {
      logic       valid;
      logic       rw;
      logic       e;
      logic [1:0] size;
      logic       se;
      logic       l;
      logic       rf_le;
      logic [4:0] rd;
   } mem_t;

   typedef struct packed {
      logic       valid;
      logic       rf_le;
      logic [4:0] rd;
   } wb_t;

   function automatic ex_t ex_bubble();
      ex_t b;
      b      = '0;
      b.size = 2'b10;
      return b;
   endfunction

   function automatic mem_t to_mem(input ex_t x);
      mem_t m;
      m.valid = x.valid;
      m.rw    = x.rw;
      m.e     = x.e;
      m.size  = x.size;
      m.se    = x.se;
      m.l     = x.l;
      m.rf_le = x.rf_le;
      m.rd    = x.rd;
      return m;
   endfunction

   function automatic wb_t to_wb(input mem_t m);
      wb_t w;
      w.valid = m.valid;
      w.rf_le = m.rf_le;
      w.rd    = m.rd;
      return w;
   endfunction

   logic [1:0] op_s;
   logic [2:0] op2_s;
   logic [5:0] op3_s;
   logic       i_s;
   logic [3:0] cond_s;
   logic [4:0] rd_s;
   logic [4:0] rs1_s;
   logic [4:0] rs2_s;
   logic       unused_s;

   assign op_s     = instr[31:30];
   assign op2_s    = instr[24:22];
   assign op3_s    = instr[24:19];
   assign i_s      = instr[13];
   assign cond_s   = instr[28:25];
   assign rd_s     = instr[29:25];
   assign rs1_s    = instr[18:14];
   assign rs2_s    = instr[4:0];
   assign unused_s = ^instr[12:5];

   ex_t  dec_s;
   logic legal_s;
   ex_t  ex_d, ex_q;
   mem_t mem_d, mem_q;
   wb_t  wb_d, wb_q;
   logic hazard_s;
   logic is_store_s;

   // Instruction decode into the EX control bundle
   always_comb begin
      dec_s   = ex_bubble();
      legal_s = 1'b0;
      case (op_s)
         2'b01: begin
            legal_s     = 1'b1;
            dec_s.call  = 1'b1;
            dec_s.rf_le = 1'b1;
            dec_s.rd    = 5'd15;
         end
         2'b00: begin
            case (op2_s)
               3'b010: begin
                  legal_s      = 1'b1;
                  dec_s.b      = 1'b1;
                  dec_s.use_cc = 1'b1;
                  dec_s.cond   = cond_s;
               end
               3'b100: begin
                  legal_s      = 1'b1;
                  dec_s.rf_le  = 1'b1;
                  dec_s.soh_op = 4'b0010;
                  dec_s.alu_op = 4'b1101;
                  dec_s.rd     = rd_s;
               end
               default: legal_s = 1'b0;
            endcase
         end
         2'b10: begin
            dec_s.soh_op = i_s ? 4'b0001 : 4'b0000;
            dec_s.rd     = rd_s;
            dec_s.rf_le  = 1'b1;
            dec_s.cc_we  = op3_s[4];
            case (op3_s)
               6'b000000, 6'b010000: begin legal_s = 1'b1;     dec_s.alu_op = 4'b0000; end
               6'b000100, 6'b010100: begin legal_s = 1'b1;     dec_s.alu_op = 4'b0010; end
               6'b000001, 6'b010001: begin legal_s = EN_LOGIC; dec_s.alu_op = 4'b0100; end
               6'b000010, 6'b010010: begin legal_s = EN_LOGIC; dec_s.alu_op = 4'b0101; end
               6'b000011, 6'b010011: begin legal_s = EN_LOGIC; dec_s.alu_op = 4'b0110; end
               6'b100101: begin legal_s = EN_SHIFT; dec_s.alu_op = 4'b1010; end
               6'b100110: begin legal_s = EN_SHIFT; dec_s.alu_op = 4'b1011; end
               6'b100111: begin legal_s = EN_SHIFT; dec_s.alu_op = 4'b1100; end
               6'b111000: begin
                  legal_s      = 1'b1;
                  dec_s.j_l    = 1'b1;
                  dec_s.alu_op = 4'b0000;
                  dec_s.cc_we  = 1'b0;
               end
               default: legal_s = 1'b0;
            endcase
         end
         2'b11: begin
            dec_s.soh_op = i_s ? 4'b0001 : 4'b0000;
            dec_s.rd     = rd_s;
            dec_s.e      = 1'b1;
            case (op3_s)
               6'b000000: begin legal_s = 1'b1; dec_s.l = 1'b1; dec_s.rf_le = 1'b1; dec_s.size = 2'b10; end
               6'b000001: begin legal_s = 1'b1; dec_s.l = 1'b1; dec_s.rf_le = 1'b1; dec_s.size = 2'b00; end
               6'b000010: begin legal_s = 1'b1; dec_s.l = 1'b1; dec_s.rf_le = 1'b1; dec_s.size = 2'b01; end
               6'b001001: begin
                  legal_s = 1'b1; dec_s.l = 1'b1; dec_s.rf_le = 1'b1; dec_s.size = 2'b00; dec_s.se = 1'b1;
               end
               6'b001010: begin
                  legal_s = 1'b1; dec_s.l = 1'b1; dec_s.rf_le = 1'b1; dec_s.size = 2'b01; dec_s.se = 1'b1;
               end
               6'b000100: begin legal_s = 1'b1; dec_s.rw = 1'b1; dec_s.size = 2'b10; end
               6'b000101: begin legal_s = 1'b1; dec_s.rw = 1'b1; dec_s.size = 2'b00; end
               6'b000110: begin legal_s = 1'b1; dec_s.rw = 1'b1; dec_s.size = 2'b01; end
               default:   legal_s = 1'b0;
            endcase
         end
         default: legal_s = 1'b0;
      endcase

      if (dec_s.rd == 5'd0) begin
         dec_s.rf_le = 1'b0;
      end else begin
         dec_s.rf_le = dec_s.rf_le;
      end

      // Illegal encodings travel as a bubble tagged only by the illegal flag
      if (!id_valid) begin
         dec_s = ex_bubble();
      end else if (!legal_s) begin
         dec_s         = ex_bubble();
         dec_s.illegal = 1'b1;
      end else begin
         dec_s.valid = 1'b1;
      end
   end

   // Load-use detection against the load currently in EX
   always_comb begin
      is_store_s = 1'b0;
      hazard_s   = 1'b0;
      if (op_s == 2'b11 && (op3_s == 6'b000100 || op3_s == 6'b000101 || op3_s == 6'b000110)) begin
         is_store_s = 1'b1;
      end else begin
         is_store_s = 1'b0;
      end
      if (HAZARD_DETECT && id_valid && ex_q.valid && ex_q.l && ex_q.rd != 5'd0) begin
         hazard_s = (op_s[1] && rs1_s == ex_q.rd)
                 || (op_s[1] && !i_s && rs2_s == ex_q.rd)
                 || (is_store_s && rd_s == ex_q.rd);
      end else begin
         hazard_s = 1'b0;
      end
   end

   assign id_hold = hazard_s && !stall && !flush;

   // Stage-register advance: stall freezes, flush/hazard inject an EX bubble
   always_comb begin
      ex_d  = ex_q;
      mem_d = mem_q;
      wb_d  = wb_q;
      if (stall) begin
         ex_d = ex_q;
      end else begin
         mem_d = to_mem(ex_q);
         wb_d  = to_wb(mem_q);
         if (flush || hazard_s) begin
            ex_d = ex_bubble();
         end else begin
            ex_d = dec_s;
         end
      end
   end

   // Stage registers with synchronous reset to a bubble
   always_ff @(posedge clk) begin
      if (reset) begin
         ex_q  <= ex_bubble();
         mem_q <= to_mem(ex_bubble());
         wb_q  <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
         wb_q  <= wb_d;
      end
   end

   assign ex_valid   = ex_q.valid;
   assign ex_soh_op  = ex_q.soh_op;
   assign ex_alu_op  = ex_q.alu_op;
   assign ex_cc_we   = ex_q.cc_we;
   assign ex_use_cc  = ex_q.use_cc;
   assign ex_b       = ex_q.b;
   assign ex_cond    = ex_q.cond;
   assign ex_j_l     = ex_q.j_l;
   assign ex_call    = ex_q.call;
   assign ex_illegal = ex_q.illegal;
   assign mem_valid  = mem_q.valid;
   assign mem_rw     = mem_q.rw;
   assign mem_e      = mem_q.e;
   assign mem_size   = mem_q.size;
   assign mem_se     = mem_q.se;
   assign mem_l      = mem_q.l;
   assign wb_valid   = wb_q.valid;
   assign wb_rf_le   = wb_q.rf_le;
   assign wb_rd      = wb_q.rd;

endmodule

// File: tb/tb_sparc_ctrl_pipe.sv
// Directed, table-driven bench for sparc_ctrl_pipe (full and reduced-decode builds).
module tb_sparc_ctrl_pipe;

   logic        clk = 1'b0;
   logic        reset, id_valid, stall, flush;
   logic [31:0] instr;

   logic id_hold, ex_valid, ex_cc_we, ex_use_cc, ex_b, ex_j_l, ex_call, ex_illegal;
   logic [3:0] ex_soh_op, ex_alu_op, ex_cond;
   logic mem_valid, mem_rw, mem_e, mem_se, mem_l, wb_valid, wb_rf_le;
   logic [1:0] mem_size;
   logic [4:0] wb_rd;

   logic n_id_hold, n_ex_valid, n_ex_cc_we, n_ex_use_cc, n_ex_b, n_ex_j_l, n_ex_call, n_ex_illegal;
   logic [3:0] n_ex_soh_op, n_ex_alu_op, n_ex_cond;
   logic n_mem_valid, n_mem_rw, n_mem_e, n_mem_se, n_mem_l, n_wb_valid, n_wb_rf_le;
   logic [1:0] n_mem_size;
   logic [4:0] n_wb_rd;

   sparc_ctrl_pipe dut (
      .clk(clk), .reset(reset), .instr(instr), .id_valid(id_valid), .stall(stall), .flush(flush),
      .id_hold(id_hold), .ex_valid(ex_valid), .ex_soh_op(ex_soh_op), .ex_alu_op(ex_alu_op),
      .ex_cc_we(ex_cc_we), .ex_use_cc(ex_use_cc), .ex_b(ex_b), .ex_cond(ex_cond), .ex_j_l(ex_j_l),
      .ex_call(ex_call), .ex_illegal(ex_illegal), .mem_valid(mem_valid), .mem_rw(mem_rw),
      .mem_e(mem_e), .mem_size(mem_size), .mem_se(mem_se), .mem_l(mem_l),
      .wb_valid(wb_valid), .wb_rf_le(wb_rf_le), .wb_rd(wb_rd));

   sparc_ctrl_pipe #(.EN_LOGIC(1'b0), .EN_SHIFT(1'b0), .HAZARD_DETECT(1'b0)) dut_n (
      .clk(clk), .reset(reset), .instr(instr), .id_valid(id_valid), .stall(stall), .flush(flush),
      .id_hold(n_id_hold), .ex_valid(n_ex_valid), .ex_soh_op(n_ex_soh_op), .ex_alu_op(n_ex_alu_op),
      .ex_cc_we(n_ex_cc_we), .ex_use_cc(n_ex_use_cc), .ex_b(n_ex_b), .ex_cond(n_ex_cond), .ex_j_l(n_ex_j_l),
      .ex_call(n_ex_call), .ex_illegal(n_ex_illegal), .mem_valid(n_mem_valid), .mem_rw(n_mem_rw),
      .mem_e(n_mem_e), .mem_size(n_mem_size), .mem_se(n_mem_se), .mem_l(n_mem_l),
      .wb_valid(n_wb_valid), .wb_rf_le(n_wb_rf_le), .wb_rd(n_wb_rd));

   always #5 clk = ~clk;

   logic [18:0] ex_vec, n_ex_vec;
   logic [8:0]  mem_vec;
   logic [6:0]  wb_vec, n_wb_vec;
   assign ex_vec   = {ex_valid, ex_illegal, ex_soh_op, ex_alu_op, ex_cc_we, ex_use_cc, ex_b, ex_cond, ex_j_l, ex_call};
   assign n_ex_vec = {n_ex_valid, n_ex_illegal, n_ex_soh_op, n_ex_alu_op, n_ex_cc_we, n_ex_use_cc, n_ex_b,
                      n_ex_cond, n_ex_j_l, n_ex_call};
   assign mem_vec  = {mem_valid, mem_rw, mem_e, mem_size, mem_se, mem_l, ex_valid, ex_illegal};
   assign wb_vec   = {wb_valid, wb_rf_le, wb_rd};
   assign n_wb_vec = {n_wb_valid, n_wb_rf_le, n_wb_rd};

   int n_cmp = 0;
   int n_fail = 0;

   typedef struct {
      logic [31:0] instr;
      logic        idv;
      logic [18:0] ex;
      logic [8:0]  mem;
      logic [6:0]  wb;
   } vec_t;
   vec_t tbl[$];

   function automatic logic [18:0] exv(input logic v, input logic ill, input logic [3:0] soh, input logic [3:0] alu,
                                       input logic cc, input logic ucc, input logic b, input logic [3:0] cond,
                                       input logic jl, input logic call);
      return {v, ill, soh, alu, cc, ucc, b, cond, jl, call};
   endfunction

   // memory-stage fields, with the EX stage expected to hold a plain bubble
   function automatic logic [8:0] memv(input logic v, input logic rw, input logic e, input logic [1:0] sz,
                                       input logic se, input logic l);
      return {v, rw, e, sz, se, l, 2'b00};
   endfunction

   function automatic logic [6:0] wbv(input logic v, input logic le, input logic [4:0] rd);
      return {v, le, rd};
   endfunction

   function automatic logic [31:0] f3(input logic [1:0] op, input logic [4:0] rd, input logic [5:0] op3,
                                      input logic [4:0] rs1, input logic i, input logic [12:0] lo);
      return {op, rd, op3, rs1, i, lo};
   endfunction

   function automatic logic [31:0] f2(input logic [4:0] rd, input logic [2:0] op2, input logic [21:0] imm);
      return {2'b00, rd, op2, imm};
   endfunction

   task automatic add(input logic [31:0] in, input logic idv, input logic [18:0] e, input logic [8:0] m,
                      input logic [6:0] w);
      vec_t v;
      v.instr = in; v.idv = idv; v.ex = e; v.mem = m; v.wb = w;
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      id_valid = 1'b0; stall = 1'b0; flush = 1'b0;
      repeat (3) step();
   endtask

   localparam logic [31:0] ADD_R3 = 32'h86004002;
   localparam logic [31:0] LD_R5  = 32'hCA006004;
   localparam logic [31:0] ADD_R6 = 32'h8C014002;

   logic [18:0] add_ex, ld_ex, bub_ex, ill_ex;
   logic [8:0]  alu_mem, bub_mem;
   logic [31:0] subcc_r4, or_r7, xorcc_r8;

   initial begin
      add_ex  = exv(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      ld_ex   = exv(1'b1, 1'b0, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      bub_ex  = 19'd0;
      ill_ex  = exv(1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      alu_mem = memv(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0);
      bub_mem = memv(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0);
      subcc_r4 = f3(2'b10, 5'd4, 6'b010100, 5'd1, 1'b1, 13'd5);
      or_r7    = f3(2'b10, 5'd7, 6'b000010, 5'd2, 1'b0, 13'd3);
      xorcc_r8 = f3(2'b10, 5'd8, 6'b010011, 5'd2, 1'b1, 13'd7);

      add(ADD_R3, 1'b1, add_ex, alu_mem, wbv(1'b1, 1'b1, 5'd3));
      add(subcc_r4, 1'b1, exv(1'b1, 1'b0, 4'd1, 4'd2, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0), alu_mem, wbv(1'b1, 1'b1, 5'd4));
      add(or_r7, 1'b1, exv(1'b1, 1'b0, 4'd0, 4'd5, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0), alu_mem, wbv(1'b1, 1'b1, 5'd7));
      add(xorcc_r8, 1'b1, exv(1'b1, 1'b0, 4'd1, 4'd6, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0), alu_mem, wbv(1'b1, 1'b1, 5'd8));
      add(f3(2'b10, 5'd20, 6'b000001, 5'd2, 1'b0, 13'd3), 1'b1,
          exv(1'b1, 1'b0, 4'd0, 4'd4, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0), alu_mem, wbv(1'b1, 1'b1, 5'd20));
      add(f3(2'b10, 5'd9, 6'b100101, 5'd1, 1'b1, 13'd3), 1'b1,
          exv(1'b1, 1'b0, 4'd1, 4'd10, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0), alu_mem, wbv(1'b1, 1'b1, 5'd9));
      add(f3(2'b10, 5'd10, 6'b100110, 5'd1, 1'b0, 13'd2), 1'b1,
          exv(1'b1, 1'b0, 4'd0, 4'd11, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0), alu_mem, wbv(1'b1, 1'b1, 5'd10));
      add(f3(2'b10, 5'd10, 6'b100111, 5'd1, 1'b1, 13'd2), 1'b1,
          exv(1'b1, 1'b0, 4'd1, 4'd12, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0), alu_mem, wbv(1'b1, 1'b1, 5'd10));
      add(f2(5'd11, 3'b100, 22'h12345), 1'b1,
          exv(1'b1, 1'b0, 4'd2, 4'd13, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0), alu_mem, wbv(1'b1, 1'b1, 5'd11));
      add(f2(5'b01001, 3'b010, 22'h10), 1'b1,
          exv(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd9, 1'b0, 1'b0), alu_mem, wbv(1'b1, 1'b0, 5'd0));
      add({2'b01, 30'h100}, 1'b1,
          exv(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1), alu_mem, wbv(1'b1, 1'b1, 5'd15));
      add(f3(2'b10, 5'd1, 6'b111000, 5'd31, 1'b1, 13'd8), 1'b1,
          exv(1'b1, 1'b0, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0), alu_mem, wbv(1'b1, 1'b1, 5'd1));
      add(f3(2'b11, 5'd13, 6'b001010, 5'd2, 1'b1, 13'd6), 1'b1, ld_ex,
          memv(1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1), wbv(1'b1, 1'b1, 5'd13));
      add(f3(2'b11, 5'd14, 6'b000001, 5'd2, 1'b0, 13'd3), 1'b1, add_ex,
          memv(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1), wbv(1'b1, 1'b1, 5'd14));
      add(f3(2'b11, 5'd14, 6'b001001, 5'd2, 1'b1, 13'd3), 1'b1, ld_ex,
          memv(1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1), wbv(1'b1, 1'b1, 5'd14));
      add(f3(2'b11, 5'd12, 6'b000101, 5'd2, 1'b1, 13'd1), 1'b1, ld_ex,
          memv(1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0), wbv(1'b1, 1'b0, 5'd12));
      add(f3(2'b11, 5'd12, 6'b000110, 5'd2, 1'b1, 13'd1), 1'b1, ld_ex,
          memv(1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0), wbv(1'b1, 1'b0, 5'd12));
      add(f3(2'b11, 5'd12, 6'b000100, 5'd2, 1'b0, 13'd1), 1'b1, add_ex,
          memv(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0), wbv(1'b1, 1'b0, 5'd12));
      add(LD_R5, 1'b1, ld_ex, memv(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1), wbv(1'b1, 1'b1, 5'd5));
      add(32'h0000_0000, 1'b1, ill_ex, bub_mem, 7'd0);
      add(f3(2'b10, 5'd3, 6'b111111, 5'd1, 1'b0, 13'd2), 1'b1, ill_ex, bub_mem, 7'd0);
      add(f3(2'b10, 5'd0, 6'b000000, 5'd1, 1'b0, 13'd2), 1'b1, add_ex, alu_mem, wbv(1'b1, 1'b0, 5'd0));
      add(ADD_R3, 1'b0, bub_ex, bub_mem, 7'd0);

      // Reset holds everything at a bubble even with a valid instruction in ID
      reset = 1'b1; instr = ADD_R3; id_valid = 1'b1; stall = 1'b0; flush = 1'b0;
      step(); step();
      chk("reset_ex", 32'(ex_vec), 32'(bub_ex));
      chk("reset_mem", 32'(mem_vec), 32'(bub_mem));
      chk("reset_wb", 32'(wb_vec), 32'd0);
      chk("reset_hold", 32'(id_hold), 32'd0);
      reset = 1'b0;
      step();
      chk("rel_ex", 32'(ex_vec), 32'(add_ex));
      step(); step();
      chk("rel_wb", 32'(wb_vec), 32'(wbv(1'b1, 1'b1, 5'd3)));

      drain();
      foreach (tbl[k]) begin
         instr = tbl[k].instr; id_valid = tbl[k].idv;
         step();
         chk($sformatf("tbl%0d_ex", k), 32'(ex_vec), 32'(tbl[k].ex));
         id_valid = 1'b0;
         step();
         chk($sformatf("tbl%0d_mem", k), 32'(mem_vec), 32'(tbl[k].mem));
         step();
         chk($sformatf("tbl%0d_wb", k), 32'(wb_vec), 32'(tbl[k].wb));
      end

      // Load-use: one bubble, then the dependent add enters EX
      drain();
      instr = LD_R5; id_valid = 1'b1; #1;
      chk("lu_nohold", 32'(id_hold), 32'd0);
      step();
      instr = ADD_R6; #1;
      chk("lu_hold", 32'(id_hold), 32'd1);
      chk("lu_nohaz_build", 32'(n_id_hold), 32'd0);
      step();
      chk("lu_bubble", 32'(ex_vec), 32'(bub_ex));
      chk("lu_mem", 32'({mem_valid, mem_e, mem_l, mem_size}), 32'({1'b1, 1'b1, 1'b1, 2'b10}));
      chk("lu_release", 32'(id_hold), 32'd0);
      step();
      chk("lu_add_ex", 32'(ex_vec), 32'(add_ex));

      // Stall freezes all three stages for two edges, then resumes in order
      drain();
      id_valid = 1'b1;
      instr = ADD_R3; step();
      instr = subcc_r4; step();
      instr = or_r7; step();
      instr = xorcc_r8; stall = 1'b1;
      for (int s = 0; s < 2; s++) begin
         step();
         chk($sformatf("stall%0d_ex", s), 32'(ex_vec), 32'(tbl[2].ex));
         chk($sformatf("stall%0d_mem", s), 32'({mem_valid, mem_rw, mem_e, mem_size, mem_se, mem_l}),
             32'({1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0}));
         chk($sformatf("stall%0d_wb", s), 32'(wb_vec), 32'(wbv(1'b1, 1'b1, 5'd3)));
      end
      stall = 1'b0;
      step();
      chk("resume_ex", 32'(ex_vec), 32'(tbl[3].ex));
      chk("resume_wb", 32'(wb_vec), 32'(wbv(1'b1, 1'b1, 5'd4)));
      id_valid = 1'b0;
      step();
      chk("resume_wb2", 32'(wb_vec), 32'(wbv(1'b1, 1'b1, 5'd7)));

      // Stall and hazard together: freeze wins, hold drops
      drain();
      instr = LD_R5; id_valid = 1'b1; step();
      instr = ADD_R6; stall = 1'b1; #1;
      chk("sh_hold", 32'(id_hold), 32'd0);
      step();
      chk("sh_ex", 32'(ex_vec), 32'(ld_ex));
      stall = 1'b0; #1;
      chk("sh_hold_after", 32'(id_hold), 32'd1);

      // Flush annuls ID while older stages keep moving
      drain();
      id_valid = 1'b1;
      instr = ADD_R3; step();
      instr = subcc_r4; step();
      instr = or_r7; flush = 1'b1; #1;
      chk("fl_hold", 32'(id_hold), 32'd0);
      step();
      flush = 1'b0;
      chk("fl_ex", 32'(ex_vec), 32'(bub_ex));
      chk("fl_mem_valid", 32'(mem_valid), 32'd1);
      chk("fl_wb", 32'(wb_vec), 32'(wbv(1'b1, 1'b1, 5'd3)));

      // Reduced-decode build rejects logic and shift ops
      drain();
      instr = or_r7; id_valid = 1'b1;
      step();
      chk("nl_or_ex", 32'(n_ex_vec), 32'(ill_ex));
      chk("full_or_alu", 32'(ex_alu_op), 32'd5);
      instr = f3(2'b10, 5'd9, 6'b100101, 5'd1, 1'b1, 13'd3);
      step();
      chk("nl_sll_ex", 32'(n_ex_vec), 32'(ill_ex));
      chk("nl_or_illegal_gone", 32'(n_mem_valid), 32'd0);
      id_valid = 1'b0;
      step();
      chk("nl_or_wb", 32'(n_wb_vec), 32'd0);

      // Reset mid-stream discards in-flight control
      id_valid = 1'b1;
      instr = ADD_R3; step();
      instr = subcc_r4; step();
      reset = 1'b1; step();
      chk("mid_reset_ex", 32'(ex_vec), 32'(bub_ex));
      chk("mid_reset_mem", 32'(mem_vec), 32'(bub_mem));
      chk("mid_reset_wb", 32'(wb_vec), 32'd0);
      reset = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
